// File: rtl/gain_agc_pkg.sv
// rtl/gain_agc_pkg.sv - shared widths and helpers for the digital gain / AGC block
package gain_agc_pkg;

  localparam int DEF_IN_W    = 32;
  localparam int DEF_OUT_W   = 16;
  localparam int DEF_NCH     = 4;
  localparam int DEF_CNT_W   = 9;
  localparam int DEF_SHIFT_W = 6;
  localparam int MAX_SHIFT   = DEF_IN_W - DEF_OUT_W;

  // Working width for helpers so they serve any IN_W below it
  localparam int WIDE_W = 64;
  localparam logic signed [WIDE_W-1:0] WIDE_ONE = {{(WIDE_W-1){1'b0}}, 1'b1};

  // Index of the highest set bit; 0 when no bit is set
  function automatic int msb_index(input logic [WIDE_W-1:0] value);
    int idx;
    idx = 0;
    for (int i = 0; i < WIDE_W; i++) begin
      if (value[i]) idx = i;
    end
    return idx;
  endfunction

  // Clamp a signed value into the signed out_w-bit range, flagging clipping
  function automatic logic signed [WIDE_W-1:0] sat_to_out(
    input  logic signed [WIDE_W-1:0] value,
    input  int                       out_w,
    output logic                     sat
  );
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    logic signed [WIDE_W-1:0] res;
    hi = (WIDE_ONE <<< (out_w - 1)) - WIDE_ONE;
    lo = -hi - WIDE_ONE;
    sat = 1'b1;
    if (value > hi) begin
      res = hi;
    end else if (value < lo) begin
      res = lo;
    end else begin
      res = value;
      sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/gain_slice.sv
// rtl/gain_slice.sv - one channel: optional round (GAIN_ROUND_EN), arithmetic shift, saturate
module gain_slice
  import gain_agc_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic [IN_W-1:0]    x,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   y,
  output logic               sat
);

  logic signed [IN_W:0]     ext;
  logic signed [IN_W:0]     shifted;
  logic signed [WIDE_W-1:0] wide;

  // One extra bit of headroom keeps the rounding add from wrapping
  always_comb begin
    ext = $signed({x[IN_W-1], x});
`ifdef GAIN_ROUND_EN
    if (shift != '0) begin
      ext = ext + $signed({{IN_W{1'b0}}, 1'b1} << (shift - 1'b1));
    end
`endif
    shifted = ext >>> shift;
    wide    = {{(WIDE_W-IN_W-1){shifted[IN_W]}}, shifted};
    sat     = 1'b0;
    y       = OUT_W'(sat_to_out(wide, OUT_W, sat));
  end

endmodule

// File: rtl/digital_gain_agc.sv
// rtl/digital_gain_agc.sv - multi-channel gain stage with frame-peak AGC; GAIN_ROUND_EN enables rounding
module digital_gain_agc
  import gain_agc_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int NCH     = DEF_NCH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ms_in,
  input  logic                   in_valid,
  input  logic [NCH*IN_W-1:0]    data_in,
  input  logic                   en_sync_in,
  input  logic [CNT_W-1:0]       cnt_sync_in,
  input  logic                   auto_mode,
  input  logic [SHIFT_W-1:0]     scaled_coeff,
  output logic [NCH*OUT_W-1:0]   data_out,
  output logic                   out_valid,
  output logic                   en_sync_out,
  output logic [CNT_W-1:0]       cnt_sync_out,
  output logic [IN_W-1:0]        max_out,
  output logic                   max_valid,
  output logic [SHIFT_W-1:0]     coeff_used,
  output logic                   sat_flag
);

  localparam int              MAX_SH  = IN_W - OUT_W;
  localparam logic [IN_W-1:0] MAG_MAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] NEG_MIN = {1'b1, {(IN_W-1){1'b0}}};

  // Most negative input has no positive twin, so it pins to the largest magnitude
  function automatic logic [IN_W-1:0] mag(input logic [IN_W-1:0] x);
    logic [IN_W-1:0] r;
    if (x == NEG_MIN)     r = MAG_MAX;
    else if (x[IN_W-1])  r = -x;
    else                 r = x;
    return r;
  endfunction

  logic [NCH*IN_W-1:0]  data1_q, data1_d;
  logic                 valid1_q, valid1_d;
  logic                 en1_q, en1_d;
  logic [CNT_W-1:0]     cnt1_q, cnt1_d;
  logic [NCH*OUT_W-1:0] data2_q, data2_d;
  logic                 sat2_q, sat2_d;
  logic                 valid2_q, valid2_d;
  logic                 en2_q, en2_d;
  logic [CNT_W-1:0]     cnt2_q, cnt2_d;
  logic [SHIFT_W-1:0]   coeff2_q, coeff2_d;
  logic [IN_W-1:0]      peak_q, peak_d;
  logic [IN_W-1:0]      max_q, max_d;
  logic                 max_valid_q, max_valid_d;
  logic [SHIFT_W-1:0]   agc_shift_q, agc_shift_d;

  logic [IN_W-1:0]      cur_mag;
  logic [IN_W-1:0]      lane_mag;
  logic [SHIFT_W-1:0]   shift_sel;
  logic [NCH*OUT_W-1:0] slice_y;
  logic [NCH-1:0]       slice_sat;
  int                   peak_msb;
  int                   agc_calc;

  // Largest magnitude among the channels presented this cycle
  always_comb begin
    cur_mag  = '0;
    lane_mag = '0;
    for (int k = 0; k < NCH; k++) begin
      lane_mag = mag(data_in[k*IN_W +: IN_W]);
      if (lane_mag > cur_mag) cur_mag = lane_mag;
    end
  end

  // Shift for the sample now in stage 1: AGC result or clamped manual value
  always_comb begin
    if (auto_mode)                              shift_sel = agc_shift_q;
    else if (scaled_coeff > SHIFT_W'(MAX_SH))   shift_sel = SHIFT_W'(MAX_SH);
    else                                        shift_sel = scaled_coeff;
  end

  // Shift that would bring the running peak just inside the output window
  always_comb begin
    peak_msb = msb_index(WIDE_W'(peak_q));
    agc_calc = peak_msb + 1 - (OUT_W - 1);
    if (peak_q == '0 || agc_calc < 0) agc_calc = 0;
    else if (agc_calc > MAX_SH)       agc_calc = MAX_SH;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slice
    gain_slice #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
    ) u_slice (
      .x     (data1_q[k*IN_W +: IN_W]),
      .shift (shift_sel),
      .y     (slice_y[k*OUT_W +: OUT_W]),
      .sat   (slice_sat[k])
    );
  end

  // Next state: two free-running pipeline stages plus frame peak / AGC update
  always_comb begin
    data1_d     = data_in;
    valid1_d    = in_valid;
    en1_d       = en_sync_in;
    cnt1_d      = cnt_sync_in;
    data2_d     = slice_y;
    sat2_d      = |slice_sat;
    valid2_d    = valid1_q;
    en2_d       = en1_q;
    cnt2_d      = cnt1_q;
    coeff2_d    = shift_sel;
    peak_d      = peak_q;
    max_d       = max_q;
    max_valid_d = 1'b0;
    agc_shift_d = agc_shift_q;
    if (ms_in) begin
      max_d       = peak_q;
      max_valid_d = 1'b1;
      agc_shift_d = SHIFT_W'(agc_calc);
      peak_d      = in_valid ? cur_mag : '0;
    end else if (in_valid && (cur_mag > peak_q)) begin
      peak_d = cur_mag;
    end
  end

  // State registers with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      data1_q     <= '0;
      valid1_q    <= 1'b0;
      en1_q       <= 1'b0;
      cnt1_q      <= '0;
      data2_q     <= '0;
      sat2_q      <= 1'b0;
      valid2_q    <= 1'b0;
      en2_q       <= 1'b0;
      cnt2_q      <= '0;
      coeff2_q    <= '0;
      peak_q      <= '0;
      max_q       <= '0;
      max_valid_q <= 1'b0;
      agc_shift_q <= '0;
    end else begin
      data1_q     <= data1_d;
      valid1_q    <= valid1_d;
      en1_q       <= en1_d;
      cnt1_q      <= cnt1_d;
      data2_q     <= data2_d;
      sat2_q      <= sat2_d;
      valid2_q    <= valid2_d;
      en2_q       <= en2_d;
      cnt2_q      <= cnt2_d;
      coeff2_q    <= coeff2_d;
      peak_q      <= peak_d;
      max_q       <= max_d;
      max_valid_q <= max_valid_d;
      agc_shift_q <= agc_shift_d;
    end
  end

  assign data_out     = data2_q;
  assign sat_flag     = sat2_q;
  assign out_valid    = valid2_q;
  assign en_sync_out  = en2_q;
  assign cnt_sync_out = cnt2_q;
  assign coeff_used   = coeff2_q;
  assign max_out      = max_q;
  assign max_valid    = max_valid_q;

endmodule
